// File: rtl/proc_control_pkg.sv
// proc_control_pkg: encodings shared by the control unit and the ALU stage.
//   - 4-bit opcodes carried in IR[15:12]
//   - 3-bit ALU operation codes, identical on both sides of the ALU interface
//   - 2-bit time-step encoding T0..T3
//   - helpers: ALU-op classification and opcode -> ALU code mapping
package proc_control_pkg;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_MVNZ = 4'b1000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } tstep_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SRL);
  endfunction

  // Non-ALU opcodes map to 000 so the ALU stage always sees a defined code.
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      OP_SLL:  return ALU_SLL;
      OP_SRL:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_control_dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder with enable.
//   sel [2:0] : register index
//   en        : when 0 the output is all zeros
//   y   [7:0] : one-hot select, bit sel set when en=1
module dec3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/proc_control.sv
// proc_control: multi-cycle control unit for the 16-bit bus processor.
// Latches the instruction into IR in T0 and sequences the datapath through
// T1..T3. Outputs are combinational decodes of the step and IR, so an
// asynchronous reset drops every enable at once.
//
// Ports:
//   Clock, Resetn : rising-edge clock, asynchronous active-low reset
//   Run           : start request, sampled only in T0
//   DIN           : instruction word in T0, immediate operand in T1 of mvi
//   Gnz           : G register non-zero, qualifies mvnz
//   IR_out        : current IR contents
//   Rin, Rout     : one-hot register load enables / bus-drive selects
//   DINout, Gout  : DIN / G drive the bus
//   Ain, Gin      : load A from bus / load G from ALU
//   alu_ctrl      : ALU operation code (valid in T2)
//   Done          : last step of the instruction
//
// step | meaning
// T0   | idle / fetch: IR <= DIN when Run
// T1   | single-step ops complete; ALU ops move Rx into A
// T2   | ALU op: Ry on bus, G <= A op bus
// T3   | ALU op: G written back to Rx
module proc_control
  import proc_control_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8   // tied to the 3-bit X/Y fields
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Gnz,
  output logic [DATA_W-1:0] IR_out,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic              DINout,
  output logic              Gout,
  output logic              Ain,
  output logic              Gin,
  output logic [2:0]        alu_ctrl,
  output logic              Done
);

  tstep_t            step;
  logic [DATA_W-1:0] ir;

  logic [3:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       alu_op;

  assign opcode = ir[15:12];
  assign rx     = ir[11:9];
  assign ry     = ir[8:6];
  assign alu_op = is_alu_op(opcode);
  assign IR_out = ir;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step <= T0;
      ir   <= '0;
    end else begin
      case (step)
        T0: if (Run) begin
          ir   <= DIN;
          step <= T1;
        end
        T1: step <= alu_op ? T2 : T0;
        T2: step <= T3;
        T3: step <= T0;
        default: step <= T0;
      endcase
    end
  end

  logic       rin_en;
  logic       rout_en;
  logic [2:0] rout_sel;

  always_comb begin
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = ry;
    DINout   = 1'b0;
    Gout     = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    alu_ctrl = ALU_ADD;
    Done     = 1'b0;
    case (step)
      T0: ;
      T1: begin
        if (alu_op) begin
          rout_en  = 1'b1;
          rout_sel = rx;
          Ain      = 1'b1;
        end else begin
          Done = 1'b1;
          case (opcode)
            OP_MV: begin
              rout_en = 1'b1;
              rin_en  = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              rin_en = 1'b1;
            end
            OP_MVNZ: begin
              rout_en = Gnz;
              rin_en  = Gnz;
            end
            default: ;
          endcase
        end
      end
      T2: if (alu_op) begin
        rout_en  = 1'b1;
        Gin      = 1'b1;
        alu_ctrl = alu_code(opcode);
      end
      T3: if (alu_op) begin
        Gout   = 1'b1;
        rin_en = 1'b1;
        Done   = 1'b1;
      end
      default: ;
    endcase
  end

  logic [7:0] rin_dec;
  logic [7:0] rout_dec;

  dec3to8 u_dec_x (
    .sel (rx),
    .en  (rin_en),
    .y   (rin_dec)
  );

  dec3to8 u_dec_y (
    .sel (rout_sel),
    .en  (rout_en),
    .y   (rout_dec)
  );

  assign Rin  = rin_dec;
  assign Rout = rout_dec;

endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: directed checks of proc_control step by step.
module tb_proc_control;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic        Gnz;
  logic [15:0] IR_out;
  logic [7:0]  Rin;
  logic [7:0]  Rout;
  logic        DINout;
  logic        Gout;
  logic        Ain;
  logic        Gin;
  logic [2:0]  alu_ctrl;
  logic        Done;

  int errors = 0;
  int checks = 0;

  proc_control dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Run      (Run),
    .DIN      (DIN),
    .Gnz      (Gnz),
    .IR_out   (IR_out),
    .Rin      (Rin),
    .Rout     (Rout),
    .DINout   (DINout),
    .Gout     (Gout),
    .Ain      (Ain),
    .Gin      (Gin),
    .alu_ctrl (alu_ctrl),
    .Done     (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packed order: Rin, Rout, DINout, Gout, Ain, Gin, alu_ctrl, Done
  task automatic chk_out(input string tag, input logic [7:0] rin, input logic [7:0] rout,
                         input logic dinout, input logic gout, input logic ain,
                         input logic gin, input logic [2:0] alu, input logic done);
    logic [23:0] obs;
    logic [23:0] exp;
    obs = {Rin, Rout, DINout, Gout, Ain, Gin, alu_ctrl, Done};
    exp = {rin, rout, dinout, gout, ain, gin, alu, done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ir(input string tag, input logic [15:0] exp);
    checks++;
    assert (IR_out === exp) else begin
      errors++;
      $error("FAIL %s IR_out observed=%h expected=%h", tag, IR_out, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk_out(tag, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  // Present an instruction in T0 and step into T1 with Run dropped.
  task automatic issue(input logic [15:0] instr);
    Run = 1'b1;
    DIN = instr;
    tick();
    Run = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = 16'hFFFF;
    Gnz    = 1'b0;

    // Reset held with Run=1 and DIN=FFFF: nothing loads, everything 0.
    #2;
    chk_idle("rst_async");
    chk_ir("rst_async_ir", 16'h0000);
    tick();
    chk_idle("rst_held");
    chk_ir("rst_held_ir", 16'h0000);

    Resetn = 1'b1;
    Run    = 1'b0;
    tick();
    chk_idle("idle_no_run");
    chk_ir("idle_no_run_ir", 16'h0000);

    // add R1,R2
    issue(16'h2280);
    chk_ir("add_ir", 16'h2280);
    chk_out("add_t1", 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    tick();
    chk_out("add_t2", 8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    tick();
    chk_out("add_t3", 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    tick();
    chk_idle("add_t0");

    // srl R5,R0 with Run held high during T1/T2 (must be ignored)
    issue(16'h7A00);
    Run = 1'b1;
    DIN = 16'h1600;
    chk_out("srl_t1", 8'h00, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    tick();
    chk_out("srl_t2", 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0);
    chk_ir("srl_t2_ir", 16'h7A00);
    tick();
    Run = 1'b0;
    chk_out("srl_t3", 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    chk_ir("srl_t3_ir", 16'h7A00);
    tick();
    chk_idle("srl_t0");

    // mvi R3, #00AB
    issue(16'h1600);
    DIN = 16'h00AB;
    chk_out("mvi_t1", 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    tick();
    chk_idle("mvi_t0");
    chk_ir("mvi_ir", 16'h1600);

    // mvnz R0,R1 with G zero, then non-zero
    Gnz = 1'b0;
    issue(16'h8040);
    chk_out("mvnz_g0_t1", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    tick();
    chk_idle("mvnz_g0_t0");
    Gnz = 1'b1;
    issue(16'h8040);
    chk_out("mvnz_g1_t1", 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    tick();
    chk_idle("mvnz_g1_t0");
    Gnz = 1'b0;

    // Back-to-back with Run held: mv R4,R4 then add R1,R2
    Run = 1'b1;
    DIN = 16'h0900;
    tick();
    DIN = 16'h2280;
    chk_out("mv_same_t1", 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    chk_ir("mv_same_ir", 16'h0900);
    tick();
    chk_idle("b2b_gap_t0");
    tick();
    Run = 1'b0;
    chk_ir("b2b_add_ir", 16'h2280);
    chk_out("b2b_add_t1", 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    tick();
    tick();
    chk_out("b2b_add_t3", 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    tick();

    // sub R1,R2 interrupted by reset in T2
    issue(16'h3280);
    tick();
    chk_out("sub_t2", 8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    chk_idle("sub_rst_async");
    chk_ir("sub_rst_ir", 16'h0000);
    #2;
    Resetn = 1'b1;
    tick();
    chk_idle("sub_rst_after");

    // Illegal opcode: Done only; Run/DIN in T1 must not reload IR
    issue(16'hF000);
    Run = 1'b1;
    DIN = 16'hFFFF;
    chk_out("illegal_t1", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    chk_ir("illegal_ir", 16'hF000);
    Run = 1'b0;
    tick();
    chk_idle("illegal_t0");
    chk_ir("illegal_t0_ir", 16'hF000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
